nq_sequencer: RTL and testbench

- Multi-cycle control FSM for the nqcpu core. It fetches 16-bit instructions over a single shared memory port and holds them in the instruction register that feeds the instruction decoder.
- It arbitrates that port between instruction fetch and the decoder's data load/store requests, and evaluates the decoder's 5-bit set-condition against the Z/S flags.
- It produces the write strobes for the register file, PC and flags.
- It sits between the decoder, register file, ALU and the memory bus.

---
 rtl/nq_pkg.sv | 36 +++
 rtl/nq_cond_eval.sv | 16 +
 rtl/nq_sequencer.sv | 169 ++++++++++++++++
 tb/tb_nq_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nq_pkg.sv
// Shared definitions for the nqcpu control path: sequencer state encoding,
// set-condition bit positions, the NOP opcode and the ALU opcode map.
package nq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_WB     = 3'd3,
        ST_FAULT  = 3'd4
    } nq_state_e;

    // dec_set_cond = {enable, Z-dontcare, S-dontcare, Z-required, S-required}
    localparam int SC_EN    = 4;
    localparam int SC_Z_DC  = 3;
    localparam int SC_S_DC  = 2;
    localparam int SC_Z_REQ = 1;
    localparam int SC_S_REQ = 0;

    localparam logic [15:0] NOP_INSTR = 16'hF000;

    localparam logic [3:0] ALU_OP_ADD = 4'h0;
    localparam logic [3:0] ALU_OP_SUB = 4'h1;
    localparam logic [3:0] ALU_OP_AND = 4'h2;
    localparam logic [3:0] ALU_OP_OR  = 4'h3;
    localparam logic [3:0] ALU_OP_XOR = 4'h4;
    localparam logic [3:0] ALU_OP_SHL = 4'h5;
    localparam logic [3:0] ALU_OP_SHR = 4'h6;
    localparam logic [3:0] ALU_OP_MOV = 4'h7;

    function automatic logic [2:0] mem_strobe_count(input logic rb, input logic rw,
                                                    input logic wb, input logic ww);
        return {2'b00, rb} + {2'b00, rw} + {2'b00, wb} + {2'b00, ww};
    endfunction

endpackage

// File: rtl/nq_cond_eval.sv
// Combinational commit decision: the instruction's results are kept only when
// the set-condition is enabled and each non-dontcare flag matches.
module nq_cond_eval
    import nq_pkg::*;
(
    input  logic [4:0] set_cond,
    input  logic       flag_z,
    input  logic       flag_s,
    output logic       commit
);

    assign commit = set_cond[SC_EN]
                  & (set_cond[SC_Z_DC] | (flag_z == set_cond[SC_Z_REQ]))
                  & (set_cond[SC_S_DC] | (flag_s == set_cond[SC_S_REQ]));

endmodule

// File: rtl/nq_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/WB sequencer for nqcpu: owns the shared memory
// port, the instruction register, the PC, the load data register and the write strobes.
module nq_sequencer
    import nq_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] instr,
    output logic [15:0] pc,
    input  logic        dec_mem_read_b,
    input  logic        dec_mem_read_w,
    input  logic        dec_mem_write_b,
    input  logic        dec_mem_write_w,
    input  logic        dec_alu_dest,
    input  logic        dec_reg_set_h,
    input  logic        dec_reg_set_l,
    input  logic [4:0]  dec_set_cond,
    input  logic        flag_z,
    input  logic        flag_s,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_word,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] mdr,
    output logic        reg_we_h,
    output logic        reg_we_l,
    output logic        pc_we,
    output logic        flags_we,
    output logic        fault,
    output nq_state_e   dbg_state
);

    // Memory handshake: mem_req and every mem_* output stay constant from the
    // cycle mem_req rises until the cycle mem_ready is seen; that same cycle
    // completes the access and mem_req is low in the following cycle.

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    nq_state_e   state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] mdr_q, mdr_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [2:0] n_mem;
    logic       acc_write, acc_word, misaligned, timed_out, commit;

    nq_cond_eval u_cond_eval (
        .set_cond (dec_set_cond),
        .flag_z   (flag_z),
        .flag_s   (flag_s),
        .commit   (commit)
    );

    assign n_mem      = mem_strobe_count(dec_mem_read_b, dec_mem_read_w,
                                         dec_mem_write_b, dec_mem_write_w);
    assign acc_write  = dec_mem_write_b | dec_mem_write_w;
    assign acc_word   = dec_mem_read_w | dec_mem_write_w;
    assign misaligned = acc_word & data_addr[0];
    assign timed_out  = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            mdr_q   <= 16'h0000;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        mdr_d    = mdr_q;
        cnt_d    = cnt_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_word = 1'b0;
        mem_addr = pc_q;
        reg_we_h = 1'b0;
        reg_we_l = 1'b0;
        pc_we    = 1'b0;
        flags_we = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_word = 1'b1;
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    pc_d    = pc_q + 16'd2;
                    state_d = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DECODE: begin
                cnt_d = 8'h00;
                if (n_mem > 3'd1)       state_d = ST_FAULT;
                else if (n_mem == 3'd1) state_d = ST_MEM;
                else                    state_d = ST_WB;
            end
            ST_MEM: begin
                mem_addr = data_addr;
                if (misaligned) begin
                    state_d = ST_FAULT;
                end else begin
                    mem_req  = 1'b1;
                    mem_we   = acc_write;
                    mem_word = acc_word;
                    if (mem_ready) begin
                        if (!acc_write)
                            mdr_d = acc_word ? mem_rdata : {mem_rdata[7:0], mem_rdata[7:0]};
                        state_d = ST_WB;
                    end else if (timed_out) begin
                        state_d = ST_FAULT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_WB: begin
                reg_we_h = commit & ~dec_alu_dest & dec_reg_set_h;
                reg_we_l = commit & ~dec_alu_dest & dec_reg_set_l;
                pc_we    = commit & dec_alu_dest;
                flags_we = commit & ~dec_alu_dest;
                cnt_d    = 8'h00;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_FAULT;
        endcase

        // Reset aborts any access in the cycle it is seen.
        if (reset) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            reg_we_h = 1'b0;
            reg_we_l = 1'b0;
            pc_we    = 1'b0;
            flags_we = 1'b0;
        end
    end

    assign instr     = instr_q;
    assign pc        = pc_q;
    assign mdr       = mdr_q;
    assign mem_wdata = data_wdata;
    assign fault     = (state_q == ST_FAULT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nq_sequencer.sv
// Directed bench for nq_sequencer: inputs change and outputs are checked at the falling edge.
module tb_nq_sequencer;
    import nq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr, pc, mem_addr, mem_wdata, mdr;
    logic        dec_mem_read_b, dec_mem_read_w, dec_mem_write_b, dec_mem_write_w;
    logic        dec_alu_dest, dec_reg_set_h, dec_reg_set_l;
    logic [4:0]  dec_set_cond;
    logic        flag_z, flag_s;
    logic [15:0] data_addr, data_wdata, mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_word;
    logic        reg_we_h, reg_we_l, pc_we, flags_we, fault;
    nq_state_e   dbg_state;

    int checks = 0;
    int errors = 0;

    nq_sequencer #(.RESET_PC(16'h0100), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc),
        .dec_mem_read_b(dec_mem_read_b), .dec_mem_read_w(dec_mem_read_w),
        .dec_mem_write_b(dec_mem_write_b), .dec_mem_write_w(dec_mem_write_w),
        .dec_alu_dest(dec_alu_dest), .dec_reg_set_h(dec_reg_set_h), .dec_reg_set_l(dec_reg_set_l),
        .dec_set_cond(dec_set_cond), .flag_z(flag_z), .flag_s(flag_s),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_word(mem_word),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mdr(mdr), .reg_we_h(reg_we_h), .reg_we_l(reg_we_l), .pc_we(pc_we),
        .flags_we(flags_we), .fault(fault), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_dec();
        dec_mem_read_b = 0; dec_mem_read_w = 0; dec_mem_write_b = 0; dec_mem_write_w = 0;
        dec_alu_dest = 0; dec_reg_set_h = 0; dec_reg_set_l = 0; dec_set_cond = 5'b00000;
        flag_z = 0; flag_s = 0; data_addr = 16'h0000; data_wdata = 16'h0000;
    endtask

    task automatic apply_reset();
        reset = 1'b1; mem_ready = 1'b0; mem_rdata = 16'h0000;
        clear_dec();
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        clear_dec();
        dec_set_cond = 5'b11100; dec_reg_set_h = 1; dec_reg_set_l = 1;
        tick(); tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL reset_pc: got %h want 0100", pc); end
        checks++; if (instr !== 16'hF000) begin errors++; $display("FAIL reset_instr: got %h want F000", instr); end
        checks++; if (mdr !== 16'h0000) begin errors++; $display("FAIL reset_mdr: got %h want 0000", mdr); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (dbg_state !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_FETCH); end
        checks++; if ({reg_we_h, reg_we_l, pc_we, flags_we} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {reg_we_h, reg_we_l, pc_we, flags_we}); end
        reset = 1'b0; mem_ready = 1'b0; clear_dec();
        #1;
    endtask

    task automatic test_add();
        clear_dec();
        dec_set_cond = 5'b11100; dec_reg_set_h = 1; dec_reg_set_l = 1;
        mem_ready = 1; mem_rdata = 16'h0123;
        #1;
        checks++; if ({mem_req, mem_we, mem_word} !== 3'b101) begin errors++; $display("FAIL add_fetch_ctl: got %b want 101", {mem_req, mem_we, mem_word}); end
        checks++; if (mem_addr !== 16'h0100) begin errors++; $display("FAIL add_fetch_addr: got %h want 0100", mem_addr); end
        tick();
        checks++; if (instr !== 16'h0123) begin errors++; $display("FAIL add_instr: got %h want 0123", instr); end
        checks++; if (pc !== 16'h0102) begin errors++; $display("FAIL add_pc: got %h want 0102", pc); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL add_decode_req: got %b want 0", mem_req); end
        tick();
        checks++; if ({reg_we_h, reg_we_l, pc_we, flags_we} !== 4'b1101) begin errors++; $display("FAIL add_wb_strobes: got %b want 1101", {reg_we_h, reg_we_l, pc_we, flags_we}); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0102) begin errors++; $display("FAIL add_next_fetch: got req=%b addr=%h want req=1 addr=0102", mem_req, mem_addr); end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 2; k++) begin
            clear_dec();
            dec_set_cond = 5'b10110; dec_alu_dest = 1; flag_z = (k == 0);
            mem_ready = 1; mem_rdata = 16'h8042;
            tick(); tick();
            checks++; if ({reg_we_h, reg_we_l, pc_we, flags_we} !== ((k == 0) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL branch_wb_z%0d: got %b want %b", 1 - k, {reg_we_h, reg_we_l, pc_we, flags_we}, (k == 0) ? 4'b0010 : 4'b0000); end
            tick();
            checks++; if (mem_addr !== ((k == 0) ? 16'h0104 : 16'h0106)) begin errors++; $display("FAIL branch_next_fetch_z%0d: got %h want %h", 1 - k, mem_addr, (k == 0) ? 16'h0104 : 16'h0106); end
        end
    endtask

    task automatic test_byte_load();
        clear_dec();
        dec_mem_read_b = 1; dec_reg_set_h = 1; dec_set_cond = 5'b11100; data_addr = 16'h2001;
        mem_ready = 1; mem_rdata = 16'h5A10;
        tick();
        mem_rdata = 16'h00A5;
        tick();
        checks++; if (dbg_state !== ST_MEM) begin errors++; $display("FAIL bload_state: got %0d want %0d", dbg_state, ST_MEM); end
        checks++; if ({mem_req, mem_we, mem_word} !== 3'b100) begin errors++; $display("FAIL bload_ctl: got %b want 100", {mem_req, mem_we, mem_word}); end
        checks++; if (mem_addr !== 16'h2001) begin errors++; $display("FAIL bload_addr: got %h want 2001", mem_addr); end
        tick();
        checks++; if (mdr !== 16'hA5A5) begin errors++; $display("FAIL bload_mdr: got %h want A5A5", mdr); end
        checks++; if ({reg_we_h, reg_we_l, pc_we, flags_we} !== 4'b1001) begin errors++; $display("FAIL bload_wb: got %b want 1001", {reg_we_h, reg_we_l, pc_we, flags_we}); end
        tick();
        checks++; if (dbg_state !== ST_FETCH || mem_addr !== 16'h0108) begin errors++; $display("FAIL bload_next_fetch: got st=%0d addr=%h want st=0 addr=0108", dbg_state, mem_addr); end
    endtask

    task automatic test_word_load();
        clear_dec();
        dec_mem_read_w = 1; dec_reg_set_h = 1; dec_reg_set_l = 1; dec_set_cond = 5'b11100;
        data_addr = 16'h3000; data_wdata = 16'h7777;
        mem_ready = 1; mem_rdata = 16'h4100;
        tick();
        mem_rdata = 16'hBEEF;
        tick();
        checks++; if ({mem_req, mem_we, mem_word} !== 3'b101 || mem_wdata !== 16'h7777) begin errors++; $display("FAIL wload_ctl: got %b wdata=%h want 101 wdata=7777", {mem_req, mem_we, mem_word}, mem_wdata); end
        tick();
        checks++; if (mdr !== 16'hBEEF) begin errors++; $display("FAIL wload_mdr: got %h want BEEF", mdr); end
        checks++; if ({reg_we_h, reg_we_l, pc_we, flags_we} !== 4'b1101) begin errors++; $display("FAIL wload_wb: got %b want 1101", {reg_we_h, reg_we_l, pc_we, flags_we}); end
        tick();
    endtask

    task automatic test_fetch_wait();
        clear_dec();
        mem_ready = 0; mem_rdata = 16'hF000;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h010A) begin errors++; $display("FAIL fwait_hold_%0d: got req=%b addr=%h want req=1 addr=010A", i, mem_req, mem_addr); end
            if (i == 3) mem_ready = 1;
            tick();
        end
        checks++; if (dbg_state !== ST_DECODE || pc !== 16'h010C) begin errors++; $display("FAIL fwait_decode: got st=%0d pc=%h want st=1 pc=010C", dbg_state, pc); end
        tick();
        checks++; if ({reg_we_h, reg_we_l, pc_we, flags_we} !== 4'b0000) begin errors++; $display("FAIL fwait_wb_nocommit: got %b want 0000", {reg_we_h, reg_we_l, pc_we, flags_we}); end
        tick();
    endtask

    task automatic test_timeout();
        clear_dec();
        mem_ready = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_req !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL tmo_wait_%0d: got req=%b fault=%b want req=1 fault=0", i, mem_req, fault); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1;
            checks++; if (fault !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL tmo_fault_%0d: got fault=%b req=%b want fault=1 req=0", i, fault, mem_req); end
            tick();
        end
    endtask

    task automatic test_misaligned_store();
        clear_dec();
        dec_mem_write_w = 1; data_addr = 16'h2003; data_wdata = 16'h1234;
        mem_ready = 1; mem_rdata = 16'h6000;
        tick(); tick();
        checks++; if (dbg_state !== ST_MEM || mem_req !== 1'b0) begin errors++; $display("FAIL mis_mem_noreq: got st=%0d req=%b want st=2 req=0", dbg_state, mem_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fault !== 1'b1 || mem_req !== 1'b0 || {reg_we_h, reg_we_l, pc_we, flags_we} !== 4'b0000) begin errors++; $display("FAIL mis_fault_%0d: got fault=%b req=%b strobes=%b want 1/0/0000", i, fault, mem_req, {reg_we_h, reg_we_l, pc_we, flags_we}); end
        end
    endtask

    task automatic test_multi_strobe();
        clear_dec();
        dec_mem_read_b = 1; dec_mem_read_w = 1; data_addr = 16'h2000;
        mem_ready = 1;
        tick(); tick();
        checks++; if (fault !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL multi_fault: got fault=%b req=%b want fault=1 req=0", fault, mem_req); end
    endtask

    task automatic test_reset_mid_mem();
        clear_dec();
        dec_mem_read_w = 1; data_addr = 16'h3000;
        mem_ready = 1; mem_rdata = 16'h4100;
        tick();
        mem_ready = 0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3000) begin errors++; $display("FAIL rmid_req: got req=%b addr=%h want req=1 addr=3000", mem_req, mem_addr); end
        tick();
        reset = 1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_same_cycle: got %b want 0", mem_req); end
        tick();
        checks++; if (mem_req !== 1'b0 || pc !== 16'h0100 || dbg_state !== ST_FETCH) begin errors++; $display("FAIL rmid_after: got req=%b pc=%h st=%0d want req=0 pc=0100 st=0", mem_req, pc, dbg_state); end
        reset = 0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin errors++; $display("FAIL rmid_restart: got req=%b addr=%h want req=1 addr=0100", mem_req, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_byte_load();
        test_word_load();
        test_fetch_wait();
        test_timeout();
        apply_reset();
        test_misaligned_store();
        apply_reset();
        test_multi_strobe();
        apply_reset();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
